// File: rtl/smpl_buf_sequencer_if.sv
// Bundle of sample strobe, RAM address/control and status signals between the
// sample source/FIR datapath (master) and smpl_buf_sequencer (slave).
interface smpl_buf_sequencer_if #(
  parameter int AW = 11,
  parameter int CW = 10
);
  logic          wrt_smpl;
  logic          clr_ovr;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic [CW-1:0] coeff_addr;
  logic          sequencing;
  logic          seq_last;
  logic          primed;
  logic          overrun;

  modport master (
    output wrt_smpl, clr_ovr,
    input  ram_we, ram_waddr, ram_raddr, coeff_addr,
           sequencing, seq_last, primed, overrun
  );

  modport slave (
    input  wrt_smpl, clr_ovr,
    output ram_we, ram_waddr, ram_raddr, coeff_addr,
           sequencing, seq_last, primed, overrun
  );
endinterface

// File: rtl/smpl_buf_sequencer.sv
// Circular sample-buffer sequencer: write pointer, fill/prime tracking and TAPS-long
// read bursts (oldest to newest) for an FIR MAC. Optional macro SMPL_DIV_EN gates input.
module smpl_buf_sequencer #(
  parameter int DEPTH = 1536,
  parameter int AW    = 11,
  parameter int TAPS  = 1021,
  parameter int CW    = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  smpl_buf_sequencer_if.slave  bus_io
);

  localparam int FW = $clog2(TAPS + 1);

  localparam logic [0:0]    IDLE  = 1'b0;
  localparam logic [0:0]    BURST = 1'b1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   TAPS_M1_X = (AW+1)'(TAPS - 1);
  localparam logic [AW:0]   DEPTH_X   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_K    = CW'(TAPS - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(TAPS);
  localparam logic [FW-1:0] FILL_M1   = FW'(TAPS - 1);

  logic          accept;
  logic [0:0]    state_q,   state_d;
  logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [FW-1:0] fill_q,    fill_d;
  logic          pending_q, pending_d;
  logic          primed_q,  primed_d;
  logic          ovr_q,     ovr_d;
  logic          we_q,      we_d;
  logic [AW-1:0] waddr_q,   waddr_d;
  logic [AW-1:0] raddr_q,   raddr_d;
  logic [CW-1:0] coeff_q,   coeff_d;
  logic [AW:0]   waddr_x;
  logic [AW:0]   start_x;

`ifdef SMPL_DIV_EN
  logic [9:0] tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= '0;
    else        tick_q <= tick_q + 10'd1;
  end

  assign accept = bus_io.wrt_smpl && (tick_q == 10'h3FF);
`else
  assign accept = bus_io.wrt_smpl;
`endif

  // Oldest tap of the window ending at the newest written address, modulo DEPTH.
  assign waddr_x = {1'b0, waddr_q};
  assign start_x = (waddr_x >= TAPS_M1_X) ? (waddr_x - TAPS_M1_X)
                                          : (waddr_x + DEPTH_X - TAPS_M1_X);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    pending_d = pending_q;
    primed_d  = primed_q;
    ovr_d     = ovr_q;
    we_d      = accept;
    waddr_d   = waddr_q;
    raddr_d   = raddr_q;
    coeff_d   = coeff_q;

    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d   = BURST;
          raddr_d   = start_x[AW-1:0];
          coeff_d   = '0;
          pending_d = 1'b0;
        end
      end
      BURST: begin
        if (coeff_q == LAST_K) begin
          state_d = IDLE;
        end else begin
          raddr_d = (raddr_q == LAST_ADDR) ? '0 : raddr_q + AW'(1);
          coeff_d = coeff_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus_io.clr_ovr) ovr_d = 1'b0;

    // A new sample overrides the pending clear above and always sets overrun if one was owed.
    if (accept) begin
      waddr_d  = wr_ptr_q;
      wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + AW'(1);
      if (fill_q != FILL_FULL) fill_d = fill_q + FW'(1);
      if (fill_q >= FILL_M1) begin
        primed_d  = 1'b1;
        pending_d = 1'b1;
      end
      if (pending_q) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      pending_q <= 1'b0;
      primed_q  <= 1'b0;
      ovr_q     <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      raddr_q   <= '0;
      coeff_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      pending_q <= pending_d;
      primed_q  <= primed_d;
      ovr_q     <= ovr_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
      coeff_q   <= coeff_d;
    end
  end

  assign bus_io.ram_we     = we_q;
  assign bus_io.ram_waddr  = waddr_q;
  assign bus_io.ram_raddr  = raddr_q;
  assign bus_io.coeff_addr = coeff_q;
  assign bus_io.sequencing = (state_q == BURST);
  assign bus_io.seq_last   = (state_q == BURST) && (coeff_q == LAST_K);
  assign bus_io.primed     = primed_q;
  assign bus_io.overrun    = ovr_q;

endmodule

// File: tb/tb_smpl_buf_sequencer.sv
// Bench for smpl_buf_sequencer with DEPTH=8, TAPS=4: directed scenarios plus random
// strobes, all compared every cycle against a burst-schedule model.
module tb_smpl_buf_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TAPS  = 4;
  localparam int CW    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  smpl_buf_sequencer_if #(.AW(AW), .CW(CW)) bus ();

  smpl_buf_sequencer #(.DEPTH(DEPTH), .AW(AW), .TAPS(TAPS), .CW(CW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkEn     = 1'b0;

  int mWe = 0, mWaddr = 0, mRaddr = 0, mCoeff = 0;
  int mSeq = 0, mLast = 0, mPrimed = 0, mOvr = 0;
  int wrIdx = 0, fillCnt = 0, owed = 0, burstK = -1, burstStart = 0, tickM = 0;
  int acc, oldOwed;
  int wrapWin [4] = '{6, 7, 0, 1};
  int weCount, waited;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit wrt, input bit clr);
    @(negedge clk);
    bus.wrt_smpl = wrt;
    bus.clr_ovr  = clr;
  endtask

  // Model: a write counter plus "one burst owed" flag; bursts are windows ending at the newest sample.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mWe = 0; mWaddr = 0; mRaddr = 0; mCoeff = 0;
      mSeq = 0; mLast = 0; mPrimed = 0; mOvr = 0;
      wrIdx = 0; fillCnt = 0; owed = 0; burstK = -1; burstStart = 0; tickM = 0;
    end else begin
      acc = bus.wrt_smpl;
`ifdef SMPL_DIV_EN
      acc = (acc != 0 && tickM == 1023) ? 1 : 0;
      tickM = (tickM + 1) % 1024;
`endif
      oldOwed = owed;
      if (burstK >= 0) begin
        burstK = (burstK == TAPS - 1) ? -1 : burstK + 1;
      end else if (owed != 0) begin
        burstK     = 0;
        burstStart = ((mWaddr - (TAPS - 1)) % DEPTH + DEPTH) % DEPTH;
        owed       = 0;
      end
      mWe = acc;
      if (bus.clr_ovr) mOvr = 0;
      if (acc != 0) begin
        mWaddr = wrIdx;
        wrIdx  = (wrIdx + 1) % DEPTH;
        if (fillCnt < TAPS) fillCnt++;
        if (fillCnt == TAPS) begin
          mPrimed = 1;
          owed    = 1;
        end
        if (oldOwed != 0) mOvr = 1;
      end
      mSeq  = (burstK >= 0) ? 1 : 0;
      mLast = (burstK == TAPS - 1) ? 1 : 0;
      if (mSeq != 0) begin
        mRaddr = (burstStart + burstK) % DEPTH;
        mCoeff = burstK;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("m_ram_we",     bus.ram_we,     mWe);
      checkOutput("m_ram_waddr",  bus.ram_waddr,  mWaddr);
      checkOutput("m_ram_raddr",  bus.ram_raddr,  mRaddr);
      checkOutput("m_coeff_addr", bus.coeff_addr, mCoeff);
      checkOutput("m_sequencing", bus.sequencing, mSeq);
      checkOutput("m_seq_last",   bus.seq_last,   mLast);
      checkOutput("m_primed",     bus.primed,     mPrimed);
      checkOutput("m_overrun",    bus.overrun,    mOvr);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.wrt_smpl = 1'b0;
    bus.clr_ovr  = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("rst_we",      bus.ram_we,     0);
    checkOutput("rst_seq",     bus.sequencing, 0);
    checkOutput("rst_primed",  bus.primed,     0);
    checkOutput("rst_overrun", bus.overrun,    0);
    checkOutput("rst_waddr",   bus.ram_waddr,  0);
    @(negedge clk);
    #2 rst_n = 1'b1;

`ifdef SMPL_DIV_EN
    bus.wrt_smpl = 1'b1;
    weCount = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      weCount += int'(bus.ram_we);
    end
    checkOutput("div_writes", weCount, 2);
    checkOutput("div_waddr",  bus.ram_waddr, 1);
    bus.wrt_smpl = 1'b0;
`else
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0);
      applyStimulus(0, 0);
      checkOutput("prime_we",     bus.ram_we,     1);
      checkOutput("prime_waddr",  bus.ram_waddr,  i);
      checkOutput("prime_primed", bus.primed,     0);
      checkOutput("prime_seq",    bus.sequencing, 0);
    end
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    checkOutput("fourth_waddr",  bus.ram_waddr,  3);
    checkOutput("fourth_primed", bus.primed,     1);
    checkOutput("fourth_seq",    bus.sequencing, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0);
      checkOutput("b1_seq",   bus.sequencing, 1);
      checkOutput("b1_raddr", bus.ram_raddr,  k);
      checkOutput("b1_coeff", bus.coeff_addr, k);
      checkOutput("b1_last",  bus.seq_last,   (k == 3) ? 1 : 0);
    end
    applyStimulus(0, 0);
    checkOutput("b1_end_seq",   bus.sequencing, 0);
    checkOutput("b1_end_raddr", bus.ram_raddr,  3);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0);
      repeat (7) applyStimulus(0, 0);
    end
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    checkOutput("wrap_waddr", bus.ram_waddr, 1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 0);
      checkOutput("wrap_raddr", bus.ram_raddr, wrapWin[k]);
      checkOutput("wrap_last",  bus.seq_last,  (k == 3) ? 1 : 0);
    end
    repeat (2) applyStimulus(0, 0);

    applyStimulus(1, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    checkOutput("mid_we",    bus.ram_we,    1);
    checkOutput("mid_waddr", bus.ram_waddr, 3);
    applyStimulus(0, 0);
    checkOutput("mid_last",  bus.seq_last,  1);
    checkOutput("mid_raddr", bus.ram_raddr, 2);
    applyStimulus(0, 0);
    checkOutput("mid_gap_seq", bus.sequencing, 0);
    applyStimulus(0, 0);
    checkOutput("mid_b2_seq",   bus.sequencing, 1);
    checkOutput("mid_b2_raddr", bus.ram_raddr,  0);
    checkOutput("mid_b2_coeff", bus.coeff_addr, 0);
    checkOutput("mid_overrun",  bus.overrun,    0);
    repeat (5) applyStimulus(0, 0);

    applyStimulus(1, 0);
    applyStimulus(0, 0);
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    checkOutput("ovr_set",   bus.overrun,   1);
    checkOutput("ovr_waddr", bus.ram_waddr, 6);
    repeat (6) applyStimulus(0, 0);
    checkOutput("ovr_b2_raddr", bus.ram_raddr,  6);
    checkOutput("ovr_b2_last",  bus.seq_last,   1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0);
      checkOutput("ovr_single_burst", bus.sequencing, 0);
    end
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    checkOutput("ovr_clr", bus.overrun, 0);
`endif

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        applyStimulus(0, 0);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
      end
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end
    applyStimulus(0, 0);

`ifndef SMPL_DIV_EN
    applyStimulus(1, 0);
    waited = 0;
    while (!bus.sequencing && waited < 20) begin
      applyStimulus(0, 0);
      waited++;
    end
    checkOutput("pre_rst_burst", bus.sequencing, 1);
    applyStimulus(0, 0);
`endif
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_seq",    bus.sequencing, 0);
    checkOutput("arst_last",   bus.seq_last,   0);
    checkOutput("arst_we",     bus.ram_we,     0);
    checkOutput("arst_primed", bus.primed,     0);
    checkOutput("arst_ovr",    bus.overrun,    0);
    checkOutput("arst_raddr",  bus.ram_raddr,  0);
    checkOutput("arst_coeff",  bus.coeff_addr, 0);
    checkOutput("arst_waddr",  bus.ram_waddr,  0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) applyStimulus(0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/smpl_buf_sequencer.md
Name: smpl_buf_sequencer

Overview:
Controller that sequences a DEPTH x 16 dual-port sample RAM used as a circular history buffer for an audio FIR datapath. It owns the write pointer, the read pointer and the RAM write-enable. For every accepted sample after priming, it issues one TAPS-long read burst (oldest to newest) with a matching coefficient index for the downstream MAC. The sample data path runs directly from source to RAM; this block generates only addresses and control.

Parameters:
DEPTH, 1536, RAM entries; need not be a power of two; pointers wrap DEPTH-1 -> 0
AW, 11, RAM address width; must satisfy 2^AW >= DEPTH
TAPS, 1021, samples per burst; legal range 2..DEPTH-1
CW, 10, coefficient index width; must satisfy 2^CW >= TAPS

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wrt_smpl  in  1  one-cycle strobe: new sample present on RAM wdata this cycle
ram_we  out  1  RAM write enable, registered
ram_waddr  out  AW  RAM write address, registered
ram_raddr  out  AW  RAM read address, registered
coeff_addr  out  CW  coefficient index aligned with ram_raddr
sequencing  out  1  high while ram_raddr/coeff_addr are valid burst addresses
seq_last  out  1  high on the final address of a burst
primed  out  1  sticky once TAPS samples have been written
overrun  out  1  sticky: a sample arrived while a burst was already pending
clr_ovr  in  1  synchronous clear of overrun

Behaviour:
- Reset: the async reset clears all outputs and internal state to 0 (wr_ptr, rd_ptr, fill, pending, state).
- Write path: wrt_smpl accepted in cycle N -> in N+1: ram_we=1, ram_waddr=wr_ptr. wr_ptr then advances, wrapping DEPTH-1 -> 0. ram_we is 0 in all other cycles. Every accepted sample is written, including during a burst.
- fill: saturating counter 0..TAPS, incremented per write. primed=1 once fill==TAPS and never clears except on reset.
- FSM states:
  - IDLE: if pending, go to BURST.
  - BURST: runs exactly TAPS cycles, then returns to IDLE.
- Burst request: a write with fill==TAPS (after its increment) sets pending in N+1.
- Burst start (entering BURST): rd_ptr = (W - (TAPS-1)) mod DEPTH, where W is the newest written address. This modular subtraction must be correct across the wrap boundary. pending clears.
- First burst address appears at N+2 at the earliest, after the write has committed.
- BURST cycle k (0..TAPS-1): ram_raddr = rd_ptr + k mod DEPTH; coeff_addr = k; sequencing=1; seq_last=1 only at k=TAPS-1.
- Last burst address equals the newest written sample. RAM rdata lags by one cycle; aligning data with coefficients is the datapath's job.
- Outside BURST: sequencing=0, seq_last=0, ram_raddr and coeff_addr hold their last value.
- Collision freedom: TAPS <= DEPTH-1, so wr_ptr never lies inside the active read window.
- wrt_smpl during BURST: the write proceeds and pending is set. The next burst starts the cycle after seq_last, i.e. back-to-back with one IDLE cycle.
- wrt_smpl while pending is already 1: the write proceeds, overrun is set, and only one burst is owed. The later burst uses the newest window.
- wrt_smpl in the seq_last cycle: treated like any other in-burst sample and sets pending.
- clr_ovr and a new overrun in the same cycle: set wins.
- Reset mid-burst: the burst is abandoned, sequencing drops immediately and fill returns to 0.

Optional Feature:
SMPL_DIV_EN
- Defined: an internal free-running 10-bit tick counter, reset to 0, qualifies the input. wrt_smpl is accepted only in cycles where tick==1023; strobes in other cycles are ignored with no write and no overrun.
- Undefined: every wrt_smpl strobe is accepted and the counter is not built.

Test Plan:
- Reset, then DEPTH=8 TAPS=4, 3 samples -> writes at addr 0,1,2; sequencing never high; primed=0.
- 4th sample (written at 3) -> primed=1; burst raddr 0,1,2,3 with coeff 0..3; seq_last on raddr 3; first raddr two cycles after the strobe.
- DEPTH=8 TAPS=4, samples continue past wrap (newest written at addr 1) -> burst raddr 6,7,0,1.
- Sample arrives mid-burst -> written immediately; second burst starts one cycle after seq_last with window shifted by 1; overrun=0.
- Two samples during one burst -> overrun=1; exactly one follow-up burst, ending at the newest address; clr_ovr -> overrun=0.
- SMPL_DIV_EN, wrt_smpl held high 2048 cycles -> exactly 2 writes, at tick==1023; assert rst_n low mid-burst -> all outputs 0 within the reset cycle.
